// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor: one prefix level per stage, valid bits
// travelling with the data, and a single global stall from the output handshake.
module pipelined_prefix_adder #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  // Status index 0 is the carry-in position (-1); index i+1 is bit i.
  localparam int NPOS = WIDTH + 1;

  function automatic logic [1:0] combine(input logic [1:0] h, input logic [1:0] l);
    return (h[1] == h[0]) ? h : l;
  endfunction

  function automatic logic resolve_carry(input logic [1:0] h, input logic l_gen);
    return (h[1] == h[0]) ? h[1] : l_gen;
  endfunction

  logic                               w_stall;
  logic [WIDTH-1:0]                   w_b_eff;
  logic                               w_cin_eff;
  logic [NPOS-1:0][1:0]               w_st_p0;
  logic [LEVELS:1][NPOS-1:0][1:0]     w_lvl;
  logic [NPOS-1:0]                    w_carry;
  logic [WIDTH-1:0]                   w_sum;

  logic [LEVELS:0]                    r_vld_p;
  logic [LEVELS:0][NPOS-1:0][1:0]     r_st_p;
  logic [LEVELS:0][WIDTH-1:0]         r_ps_p;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // ---- stage 0: per-bit status, propagate-sum bits, carry-in status ----
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;
  assign w_st_p0[0] = {2{w_cin_eff}};

  genvar gi, gk, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_status
      assign w_st_p0[gi+1] = {a[gi] & w_b_eff[gi], a[gi] | w_b_eff[gi]};
    end

    // ---- stages 1..LEVELS: one Kogge-Stone level each ----
    for (gk = 1; gk <= LEVELS; gk++) begin : g_level
      localparam int D = 1 << (gk - 1);
      for (gj = 0; gj < NPOS; gj++) begin : g_pos
        // Positions with no partner combine with themselves, which leaves them unchanged.
        localparam int SRC = (gj >= D) ? gj - D : gj;
        assign w_lvl[gk][gj] = combine(r_st_p[gk-1][gj], r_st_p[gk-1][SRC]);
      end
    end

    // ---- output stage: carries, sum, cout, ovf ----
    // The MSB's span stops one position above the carry-in, so a fully
    // propagating word is finished against the carry-in status here.
    for (gj = 0; gj < NPOS; gj++) begin : g_carry
      assign w_carry[gj] = resolve_carry(r_st_p[LEVELS][gj], r_st_p[LEVELS][0][1]);
    end
  endgenerate

  assign w_sum = r_ps_p[LEVELS] ^ w_carry[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_st_p <= {w_lvl, w_st_p0};
      r_ps_p <= {r_ps_p[LEVELS-1:0], a ^ w_b_eff};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p   <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p   <= {r_vld_p[LEVELS-1:0], in_valid};
      out_valid <= r_vld_p[LEVELS];
      if (r_vld_p[LEVELS]) begin
        sum  <= w_sum;
        cout <= w_carry[WIDTH];
        ovf  <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder (WIDTH=16): directed vectors,
// random streaming, output stall and mid-flight reset.
module tb_pipelined_prefix_adder;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_en = 1'b1;
  exp_t sb[$];

  pipelined_prefix_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.acc = 0; e.lat = 1'b0;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    logic [W-1:0] yb;
    logic [W:0]   r;
    yb = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yb} + (W+1)'(s | c);
    return mk(r[W-1:0], r[W], (x[W-1] == yb[W-1]) && (r[W-1] != x[W-1]));
  endfunction

  // Presents one operand set and waits (bounded) until it is accepted.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic ts, input exp_t e, output int waits);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 64'(waits), 0);
        in_valid = 1'b0;
        return;
      end
    end
    e.acc = cyc + 1;
    e.lat = lat_en;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain_remaining", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {47'd0, sum, cout}, 64'h1_dead_beef);
      end else begin
        e = sb.pop_front();
        check("sum", 64'(sum), 64'(e.s));
        check("cout", 64'(cout), 64'(e.c));
        check("ovf", 64'(ovf), 64'(e.o));
        if (e.lat) check("latency", 64'(cyc - e.acc), 5);
      end
    end
  end

  initial begin
    int w;
    int total_w;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_sum", 64'(sum), 0);
    check("rst_cout", 64'(cout), 0);
    check("rst_ovf", 64'(ovf), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), w);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), w);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), w);
    send(16'h0000, 16'h0000, 1'b1, 1'b0, mk(16'h0001, 1'b0, 1'b0), w);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0), w);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), w);
    send(16'h0003, 16'h0001, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0), w);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0), w);
    drain();

    // Random stream, out_ready held high: no set may wait
    total_w = 0;
    repeat (100) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
      total_w += w;
    end
    check("throughput_waits", 64'(total_w), 0);
    drain();

    // Fill the pipeline with the consumer stalled, then hold for 10 cycles
    lat_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'(i & 1);
      send(ra, rb, 1'b1, rs, model(ra, rb, 1'b1, rs), w);
    end
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_state", {out_valid, in_ready, sum, cout, ovf},
            {1'b1, 1'b0, sb[0].s, sb[0].c, sb[0].o});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("stall_all_results_out", 64'(sb.size()), 0);
    lat_en = 1'b1;

    // Reset with sets in flight and one result held at the output
    out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), w);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), w);
    for (int i = 0; i < 4; i++) send(16'(i), 16'h0101, 1'b0, 1'b0, mk('0, 1'b0, 1'b0), w);
    check("pre_reset_out_valid", 64'(out_valid), 1);
    #1 reset = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_in_ready", 64'(in_ready), 1);
    check("reset_sum", 64'(sum), 0);
    check("reset_cout_ovf", {cout, ovf}, 0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(16'h0000, 16'h0000, 1'b1, 1'b0, mk(16'h0001, 1'b0, 1'b0), w);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
